// File: rtl/mips_ctrl_pkg.sv
// mips_ctrl_pkg: state codes, instruction constants and select encodings shared by the multi-cycle control
package mips_ctrl_pkg;

   typedef enum logic [3:0] {
      S_FETCH    = 4'd0,
      S_DECODE   = 4'd1,
      S_MEM_ADDR = 4'd2,
      S_MEM_RD   = 4'd3,
      S_MEM_WB   = 4'd4,
      S_MEM_WR   = 4'd5,
      S_R_EXEC   = 4'd6,
      S_R_WB     = 4'd7,
      S_BRANCH   = 4'd8,
      S_JAL      = 4'd9,
      S_JR       = 4'd10,
      S_I_EXEC   = 4'd11,
      S_I_WB     = 4'd12,
      S_TRAP     = 4'd15
   } state_t;

   localparam logic [5:0] OP_RTYPE = 6'b000000;
   localparam logic [5:0] OP_LW    = 6'b100011;
   localparam logic [5:0] OP_SW    = 6'b101011;
   localparam logic [5:0] OP_BEQ   = 6'b000100;
   localparam logic [5:0] OP_ADDI  = 6'b001000;
   localparam logic [5:0] OP_ANDI  = 6'b001100;
   localparam logic [5:0] OP_JAL   = 6'b000011;

   localparam logic [5:0] FN_ADD = 6'b100000;
   localparam logic [5:0] FN_AND = 6'b100100;
   localparam logic [5:0] FN_NOR = 6'b100111;
   localparam logic [5:0] FN_SLT = 6'b101010;
   localparam logic [5:0] FN_SLL = 6'b000000;
   localparam logic [5:0] FN_JR  = 6'b001000;

   localparam logic [1:0] DST_RT = 2'b00, DST_RD = 2'b01, DST_RA = 2'b10;
   localparam logic [1:0] TOREG_ALU = 2'b00, TOREG_MDR = 2'b01, TOREG_PC = 2'b10;
   localparam logic [1:0] SRCB_B = 2'b00, SRCB_FOUR = 2'b01, SRCB_IMM = 2'b10, SRCB_IMM_SH = 2'b11;
   localparam logic [1:0] ALU_ADD = 2'b00, ALU_SUB = 2'b01, ALU_FUNCT = 2'b10, ALU_AND = 2'b11;
   localparam logic [1:0] PCS_ALU = 2'b00, PCS_ALUOUT = 2'b01, PCS_JUMP = 2'b10, PCS_RS = 2'b11;

   typedef struct packed {
      logic       pc_write;
      logic       pc_write_cond;
      logic       i_or_d;
      logic       mem_read;
      logic       mem_write;
      logic       ir_write;
      logic       reg_write;
      logic       alu_src_a;
      logic [1:0] reg_dst;
      logic [1:0] mem_to_reg;
      logic [1:0] alu_src_b;
      logic [1:0] alu_op;
      logic [1:0] pc_source;
   } ctrl_t;

   function automatic logic rtype_ok(input logic [5:0] fn);
      return fn == FN_ADD || fn == FN_AND || fn == FN_NOR || fn == FN_SLT || fn == FN_SLL;
   endfunction

   // jr shares the R-type opcode but skips the ALU, so it is split off here
   function automatic state_t decode_next(input logic [5:0] op, input logic [5:0] fn);
      state_t s;
      case (op)
         OP_RTYPE:         s = (fn == FN_JR) ? S_JR : rtype_ok(fn) ? S_R_EXEC : S_TRAP;
         OP_LW, OP_SW:     s = S_MEM_ADDR;
         OP_BEQ:           s = S_BRANCH;
         OP_ADDI, OP_ANDI: s = S_I_EXEC;
         OP_JAL:           s = S_JAL;
         default:          s = S_TRAP;
      endcase
      return s;
   endfunction

endpackage

// File: rtl/retire_counter.sv
// retire_counter: wrapping count of completed instructions
module retire_counter #(
   parameter int W = 32
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         en,
   output logic [W-1:0] count
);

   // one increment per retired instruction, cleared by reset
   always_ff @(posedge clk)
      if (rst) count <= '0;
      else if (en) count <= count + W'(1);

endmodule

// File: rtl/multicycle_control.sv
// multicycle_control: Moore control FSM for a multi-cycle MIPS-subset datapath
module multicycle_control
   import mips_ctrl_pkg::*;
#(
   parameter int CNT_W = 32
) (
   input  logic             clock,
   input  logic             reset,
   input  logic [5:0]       opcode,
   input  logic [5:0]       func,
   input  logic             mem_ready,
   input  logic             zero,
   output logic             PCWrite,
   output logic             PCWriteCond,
   output logic             IorD,
   output logic             MemRead,
   output logic             MemWrite,
   output logic             IRWrite,
   output logic             RegWrite,
   output logic             ALUSrcA,
   output logic [1:0]       RegDst,
   output logic [1:0]       MemtoReg,
   output logic [1:0]       ALUSrcB,
   output logic [1:0]       ALUop,
   output logic [1:0]       PCSource,
   output logic [3:0]       state,
   output logic             illegal,
   output logic [CNT_W-1:0] retired
);

   state_t st, nxt;
   ctrl_t  c, ctl;
   logic   is_sw, is_andi;
   logic   unused_zero;

   // the branch decision is made in the datapath via PCWriteCond
   assign unused_zero = zero;

   // next-state selection; unused encodings fall into the trap
   always_comb begin
      nxt = S_TRAP;
      case (st)
         S_FETCH:    nxt = mem_ready ? S_DECODE : S_FETCH;
         S_DECODE:   nxt = decode_next(opcode, func);
         S_MEM_ADDR: nxt = is_sw ? S_MEM_WR : S_MEM_RD;
         S_MEM_RD:   nxt = mem_ready ? S_MEM_WB : S_MEM_RD;
         S_MEM_WR:   nxt = mem_ready ? S_FETCH : S_MEM_WR;
         S_R_EXEC:   nxt = S_R_WB;
         S_I_EXEC:   nxt = S_I_WB;
         S_MEM_WB, S_R_WB, S_I_WB, S_BRANCH, S_JAL, S_JR: nxt = S_FETCH;
         default:    nxt = S_TRAP;
      endcase
   end

   // state register; lw/sw and addi/andi flavour is captured at decode so later states are pure Moore
   always_ff @(posedge clock)
      if (reset) begin
         st      <= S_FETCH;
         illegal <= 1'b0;
         is_sw   <= 1'b0;
         is_andi <= 1'b0;
      end else begin
         st      <= nxt;
         illegal <= illegal | (nxt == S_TRAP);
         if (st == S_DECODE) begin
            is_sw   <= opcode == OP_SW;
            is_andi <= opcode == OP_ANDI;
         end
      end

   // per-state control decode; only the fetch handshake enables look at mem_ready
   always_comb begin
      c = '0;
      case (st)
         S_FETCH: begin
            c.mem_read  = 1'b1;
            c.alu_src_b = SRCB_FOUR;
            c.ir_write  = mem_ready;
            c.pc_write  = mem_ready;
         end
         S_DECODE:   c.alu_src_b = SRCB_IMM_SH;
         S_MEM_ADDR: begin
            c.alu_src_a = 1'b1;
            c.alu_src_b = SRCB_IMM;
         end
         S_MEM_RD: begin
            c.mem_read = 1'b1;
            c.i_or_d   = 1'b1;
         end
         S_MEM_WB: begin
            c.reg_write  = 1'b1;
            c.mem_to_reg = TOREG_MDR;
         end
         S_MEM_WR: begin
            c.mem_write = 1'b1;
            c.i_or_d    = 1'b1;
         end
         S_R_EXEC: begin
            c.alu_src_a = 1'b1;
            c.alu_op    = ALU_FUNCT;
         end
         S_R_WB: begin
            c.reg_write = 1'b1;
            c.reg_dst   = DST_RD;
         end
         S_BRANCH: begin
            c.alu_src_a     = 1'b1;
            c.alu_op        = ALU_SUB;
            c.pc_write_cond = 1'b1;
            c.pc_source     = PCS_ALUOUT;
         end
         S_JAL: begin
            c.pc_write   = 1'b1;
            c.pc_source  = PCS_JUMP;
            c.reg_write  = 1'b1;
            c.reg_dst    = DST_RA;
            c.mem_to_reg = TOREG_PC;
         end
         S_JR: begin
            c.pc_write  = 1'b1;
            c.pc_source = PCS_RS;
         end
         S_I_EXEC: begin
            c.alu_src_a = 1'b1;
            c.alu_src_b = SRCB_IMM;
            c.alu_op    = is_andi ? ALU_AND : ALU_ADD;
         end
         S_I_WB:     c.reg_write = 1'b1;
         default:    c = '0;
      endcase
   end

   // nothing is enabled while reset is held, whatever the handshake does
   assign ctl = reset ? '0 : c;

   assign PCWrite     = ctl.pc_write;
   assign PCWriteCond = ctl.pc_write_cond;
   assign IorD        = ctl.i_or_d;
   assign MemRead     = ctl.mem_read;
   assign MemWrite    = ctl.mem_write;
   assign IRWrite     = ctl.ir_write;
   assign RegWrite    = ctl.reg_write;
   assign ALUSrcA     = ctl.alu_src_a;
   assign RegDst      = ctl.reg_dst;
   assign MemtoReg    = ctl.mem_to_reg;
   assign ALUSrcB     = ctl.alu_src_b;
   assign ALUop       = ctl.alu_op;
   assign PCSource    = ctl.pc_source;
   assign state       = st;

   retire_counter #(.W(CNT_W)) u_retire (
      .clk   (clock),
      .rst   (reset),
      .en    (st != S_FETCH && nxt == S_FETCH),
      .count (retired)
   );

endmodule
